// File: rtl/multi_channel_parity_fifo_if.sv
// Handshake and data bundle between push producers/pop consumer and the parity FIFO.
// Purely wiring, no storage, no added latency.
// Backpressure: push_grant_o per channel on the push side, grant_i on the pop side.
interface multi_channel_parity_fifo_if #(
  parameter int DATA_WIDTH    = 10,
  parameter int NUM_CH        = 4,
  parameter int ERR_CNT_WIDTH = 8
);
  localparam int CHW = $clog2(NUM_CH);

  logic [NUM_CH-1:0]            push_valid_i;
  logic [NUM_CH*DATA_WIDTH-1:0] push_data_i;
  logic [NUM_CH-1:0]            push_inject_err_i;
  logic [NUM_CH-1:0]            push_grant_o;
  logic                         valid_o;
  logic [DATA_WIDTH-1:0]        data_o;
  logic [CHW-1:0]               channel_o;
  logic                         parity_err_o;
  logic                         grant_i;
  logic [ERR_CNT_WIDTH-1:0]     err_count_o;
  logic                         err_count_clr_i;

  // Producer/consumer side of the block.
  modport master (
    output push_valid_i, push_data_i, push_inject_err_i, grant_i, err_count_clr_i,
    input  push_grant_o, valid_o, data_o, channel_o, parity_err_o, err_count_o
  );

  // FIFO side of the block.
  modport slave (
    input  push_valid_i, push_data_i, push_inject_err_i, grant_i, err_count_clr_i,
    output push_grant_o, valid_o, data_o, channel_o, parity_err_o, err_count_o
  );
endinterface

// File: rtl/multi_channel_parity_fifo.sv
// NUM_CH parity-protected circular queues drained round-robin into one registered pop slot.
// Latency: push at edge N is visible on valid_o after edge N+1; 1 word/cycle sustained.
// Backpressure: push_grant_o drops only when a queue is full; slot holds while grant_i is low.
package types_pkg;
  typedef enum logic {EVEN, ODD} parity_t;
  typedef enum logic {MSB, LSB}  parity_pos_t;
endpackage

module multi_channel_parity_fifo #(
  parameter int                    DATA_WIDTH        = 10,
  parameter int                    DEPTH             = 12,
  parameter int                    NUM_CH            = 4,
  parameter types_pkg::parity_t    PARITY_MODE       = types_pkg::ODD,
  parameter types_pkg::parity_pos_t PARITY_BIT_CHOICE = types_pkg::MSB,
  parameter int                    ERR_CNT_WIDTH     = 8
) (
  input logic                     clk,
  input logic                     reset,
  multi_channel_parity_fifo_if.slave bus
);
  localparam int SW  = DATA_WIDTH + 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CHW = $clog2(NUM_CH);

  logic [SW-1:0]            mem    [NUM_CH][DEPTH];
  logic [PW-1:0]            wr_ptr [NUM_CH];
  logic [PW-1:0]            rd_ptr [NUM_CH];
  logic [CW-1:0]            count  [NUM_CH];
  logic [SW-1:0]            push_word [NUM_CH];
  logic [NUM_CH-1:0]        not_empty, push_acc, pop_en;
  logic [CHW-1:0]           rr_ptr, sel, scan_idx;
  logic                     any_ne, loadable, xfer;
  logic [SW-1:0]            head_word;
  logic [DATA_WIDTH-1:0]    head_data;
  logic                     head_perr;

  logic                     valid_q, perr_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [CHW-1:0]           chan_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  // Builds the stored word: parity bit over the payload, optionally inverted for fault injection.
  function automatic logic [SW-1:0] make_word(input logic [DATA_WIDTH-1:0] d, input logic inj);
    logic p;
    p = ((PARITY_MODE == types_pkg::EVEN) ? ^d : ~^d) ^ inj;
    return (PARITY_BIT_CHOICE == types_pkg::MSB) ? {p, d} : {d, p};
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Per-channel occupancy flags, push acceptance and stored-word formation.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      not_empty[c]        = (count[c] != '0);
      bus.push_grant_o[c] = (count[c] != CW'(DEPTH));
      push_acc[c]         = bus.push_valid_i[c] && (count[c] != CW'(DEPTH));
      push_word[c]        = make_word(bus.push_data_i[c*DATA_WIDTH +: DATA_WIDTH],
                                      bus.push_inject_err_i[c]);
    end
  end

  // Round-robin pick: scan backwards so the last hit is the first non-empty after rr_ptr.
  always_comb begin
    sel      = rr_ptr;
    any_ne   = 1'b0;
    scan_idx = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      scan_idx = CHW'((int'(rr_ptr) + i) % NUM_CH);
      if (not_empty[scan_idx]) begin
        sel    = scan_idx;
        any_ne = 1'b1;
      end
    end
  end

  // Slot load decision, queue head decode and parity check of the word about to be loaded.
  always_comb begin
    xfer      = valid_q && bus.grant_i;
    loadable  = !valid_q || bus.grant_i;
    head_word = mem[sel][rd_ptr[sel]];
    head_data = (PARITY_BIT_CHOICE == types_pkg::MSB) ? head_word[DATA_WIDTH-1:0]
                                                      : head_word[SW-1:1];
    head_perr = (PARITY_MODE == types_pkg::EVEN) ? ^head_word : ~^head_word;
    for (int c = 0; c < NUM_CH; c++) begin
      pop_en[c] = loadable && any_ne && (sel == CHW'(c));
    end
  end

  // Queue storage; contents need no reset since pointers and counts gate every read.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_acc[c]) mem[c][wr_ptr[c]] <= push_word[c];
    end
  end

  // Per-channel pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push_acc[c]) wr_ptr[c] <= ptr_inc(wr_ptr[c]);
        if (pop_en[c])   rd_ptr[c] <= ptr_inc(rd_ptr[c]);
        case ({push_acc[c], pop_en[c]})
          2'b10:   count[c] <= count[c] + 1'b1;
          2'b01:   count[c] <= count[c] - 1'b1;
          default: count[c] <= count[c];
        endcase
      end
    end
  end

  // Output slot and arbiter pointer: reload on empty slot or transfer, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      perr_q  <= 1'b0;
      rr_ptr  <= CHW'(NUM_CH - 1);
    end else if (loadable) begin
      if (any_ne) begin
        valid_q <= 1'b1;
        data_q  <= head_data;
        chan_q  <= sel;
        perr_q  <= head_perr;
        rr_ptr  <= sel;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  // Saturating count of transferred words flagged with a parity error; clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (bus.err_count_clr_i) begin
      err_cnt_q <= '0;
    end else if (xfer && perr_q && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.valid_o      = valid_q;
  assign bus.data_o       = data_q;
  assign bus.channel_o    = chan_q;
  assign bus.parity_err_o = perr_q;
  assign bus.err_count_o  = err_cnt_q;
endmodule

// File: tb/tb_multi_channel_parity_fifo.sv
// Self-checking bench: queue-based reference model compared every cycle plus directed literals.
// Latency: model steps on each rising edge, DUT sampled 1 time unit later.
// Backpressure: grant_i and push_valid_i are randomized or scripted per scenario.
module tb_multi_channel_parity_fifo;
  localparam int DW = 10, DEPTH = 12, NCH = 4, ECW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multi_channel_parity_fifo_if #(.DATA_WIDTH(DW), .NUM_CH(NCH), .ERR_CNT_WIDTH(ECW)) bus ();

  multi_channel_parity_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NCH),
    .PARITY_MODE(types_pkg::ODD), .PARITY_BIT_CHOICE(types_pkg::MSB), .ERR_CNT_WIDTH(ECW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per channel, entry = {inject_flag, data}.
  int qm [NCH][$];
  bit m_vld = 1'b0;
  int m_data = 0, m_ch = 0;
  bit m_perr = 1'b0;
  int m_rr = NCH - 1;
  int m_cnt = 0;
  int pre_sz [NCH];
  bit found;
  int ent, cand;
  logic [NCH-1:0] exp_gnt;

  always @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) qm[c].delete();
      m_vld = 1'b0; m_perr = 1'b0; m_rr = NCH - 1; m_cnt = 0;
    end else begin
      for (int c = 0; c < NCH; c++) pre_sz[c] = qm[c].size();
      if (bus.err_count_clr_i) m_cnt = 0;
      else if (m_vld && bus.grant_i && m_perr && m_cnt < 255) m_cnt = m_cnt + 1;
      if (!m_vld || bus.grant_i) begin
        found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
          cand = (m_rr + i) % NCH;
          if (!found && qm[cand].size() > 0) begin
            found  = 1'b1;
            ent    = qm[cand].pop_front();
            m_data = ent & 32'h3FF;
            m_perr = (ent >> 10) & 1;
            m_ch   = cand;
            m_rr   = cand;
          end
        end
        m_vld = found;
      end
      for (int c = 0; c < NCH; c++) begin
        if (bus.push_valid_i[c] && pre_sz[c] < DEPTH)
          qm[c].push_back((int'(bus.push_inject_err_i[c]) << 10) | int'(bus.push_data_i[c*DW +: DW]));
      end
    end
    #1;
    for (int c = 0; c < NCH; c++) exp_gnt[c] = (qm[c].size() != DEPTH);
    chk("model_valid", 32'(bus.valid_o), 32'(m_vld));
    chk("model_grant", 32'(bus.push_grant_o), 32'(exp_gnt));
    chk("model_errcnt", 32'(bus.err_count_o), 32'(m_cnt));
    if (m_vld) begin
      chk("model_data", 32'(bus.data_o), 32'(m_data));
      chk("model_chan", 32'(bus.channel_o), 32'(m_ch));
      chk("model_perr", 32'(bus.parity_err_o), 32'(m_perr));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_push(input int c, input int d, input bit inj);
    bus.push_valid_i[c]        = 1'b1;
    bus.push_data_i[c*DW +: DW] = DW'(d);
    bus.push_inject_err_i[c]   = inj;
  endtask

  task automatic clr_push();
    bus.push_valid_i      = '0;
    bus.push_inject_err_i = '0;
  endtask

  int exp_seq [6] = '{1, 2, 3, 1, 2, 3};

  initial begin
    bus.push_valid_i = '0; bus.push_data_i = '0; bus.push_inject_err_i = '0;
    bus.grant_i = 1'b0; bus.err_count_clr_i = 1'b0;
    cyc(); cyc();
    chk("rst_valid", 32'(bus.valid_o), 0);
    chk("rst_errcnt", 32'(bus.err_count_o), 0);
    chk("rst_grant", 32'(bus.push_grant_o), 32'hF);
    reset = 1'b0;

    // 1: single word latency.
    bus.grant_i = 1'b1;
    set_push(0, 10'h155, 1'b0);
    cyc(); clr_push();
    chk("t1_not_yet", 32'(bus.valid_o), 0);
    cyc();
    chk("t1_valid", 32'(bus.valid_o), 1);
    chk("t1_data", 32'(bus.data_o), 32'h155);
    chk("t1_chan", 32'(bus.channel_o), 0);
    chk("t1_perr", 32'(bus.parity_err_o), 0);
    cyc();
    chk("t1_drained", 32'(bus.valid_o), 0);

    // 2: round-robin order across channels 1..3.
    bus.grant_i = 1'b0;
    for (int c = 1; c < NCH; c++) set_push(c, c, 1'b0);
    cyc(); cyc();
    clr_push(); bus.grant_i = 1'b1;
    chk("t2_ord0", 32'(bus.channel_o), 32'(exp_seq[0]));
    for (int k = 1; k < 6; k++) begin
      cyc();
      chk("t2_ord", 32'(bus.channel_o), 32'(exp_seq[k]));
      chk("t2_data", 32'(bus.data_o), 32'(exp_seq[k]));
    end
    cyc();
    chk("t2_empty", 32'(bus.valid_o), 0);

    // 3: fill ch0 behind a held slot, refused 13th push, grant returns after one pop.
    bus.grant_i = 1'b0;
    set_push(1, 10'h0AA, 1'b0);
    cyc(); clr_push(); cyc();
    chk("t3_slot", 32'(bus.data_o), 32'h0AA);
    for (int k = 0; k < DEPTH; k++) begin
      set_push(0, 10'h100 + k, 1'b0);
      cyc();
    end
    chk("t3_full", 32'(bus.push_grant_o[0]), 0);
    cyc(); clr_push();
    chk("t3_still_full", 32'(bus.push_grant_o[0]), 0);
    chk("t3_hold_vld", 32'(bus.valid_o), 1);
    chk("t3_hold_data", 32'(bus.data_o), 32'h0AA);
    bus.grant_i = 1'b1;
    cyc();
    bus.grant_i = 1'b0;
    chk("t3_regrant", 32'(bus.push_grant_o[0]), 1);
    chk("t3_head", 32'(bus.data_o), 32'h100);
    bus.grant_i = 1'b1;
    repeat (16) cyc();
    chk("t3_drained", 32'(bus.valid_o), 0);

    // 4: injected parity error, counter and clear.
    set_push(0, 10'h3FF, 1'b1);
    cyc();
    set_push(0, 10'h000, 1'b0);
    cyc(); clr_push();
    chk("t4_perr1", 32'(bus.parity_err_o), 1);
    chk("t4_data1", 32'(bus.data_o), 32'h3FF);
    cyc();
    chk("t4_perr0", 32'(bus.parity_err_o), 0);
    chk("t4_cnt1", 32'(bus.err_count_o), 1);
    cyc();
    bus.err_count_clr_i = 1'b1;
    cyc();
    bus.err_count_clr_i = 1'b0;
    chk("t4_clr", 32'(bus.err_count_o), 0);

    // 5: saturation.
    for (int k = 0; k < 300; k++) begin
      set_push(1, $urandom_range(0, 1023), 1'b1);
      cyc();
    end
    clr_push();
    repeat (5) cyc();
    chk("t5_sat", 32'(bus.err_count_o), 255);

    // Random traffic with varying backpressure.
    for (int k = 0; k < 800; k++) begin
      clr_push();
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 1)) set_push(c, $urandom_range(0, 1023), ($urandom_range(0, 7) == 0));
      bus.grant_i = (k < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      bus.err_count_clr_i = ($urandom_range(0, 63) == 0);
      cyc();
    end
    clr_push(); bus.err_count_clr_i = 1'b0; bus.grant_i = 1'b1;
    repeat (60) cyc();
    chk("rand_drained", 32'(bus.valid_o), 0);

    // 6: asynchronous reset mid-burst, then clean restart.
    bus.grant_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_push(2, 10'h050 + k, 1'b0);
      cyc();
    end
    clr_push();
    chk("t6_busy", 32'(bus.valid_o), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_vld", 32'(bus.valid_o), 0);
    chk("t6_rst_data", 32'(bus.data_o), 0);
    chk("t6_rst_chan", 32'(bus.channel_o), 0);
    chk("t6_rst_perr", 32'(bus.parity_err_o), 0);
    chk("t6_rst_cnt", 32'(bus.err_count_o), 0);
    chk("t6_rst_gnt", 32'(bus.push_grant_o), 32'hF);
    cyc();
    reset = 1'b0;
    set_push(3, 10'h2A5, 1'b0);
    cyc(); clr_push();
    chk("t6_lat1", 32'(bus.valid_o), 0);
    cyc();
    chk("t6_lat2", 32'(bus.valid_o), 1);
    chk("t6_chan", 32'(bus.channel_o), 3);
    chk("t6_data", 32'(bus.data_o), 32'h2A5);
    bus.grant_i = 1'b1;
    repeat (3) cyc();
    chk("t6_no_stale", 32'(bus.valid_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_channel_parity_fifo.md
Name: multi_channel_parity_fifo

Overview:
Parameterised multi-channel successor of the single parity-protected push/pop FIFO. NUM_CH independent circular queues each store DATA_WIDTH data plus one parity bit. A round-robin arbiter drains the non-empty queues into one registered pop port. Parity is checked on pop, flagged per word and counted, and errors can be injected on push for verification.

Parameters:
DATA_WIDTH, 10, payload bits per word
DEPTH, 12, entries per channel; any value >= 2, power of two not required
NUM_CH, 4, number of push channels (>= 2)
PARITY_MODE, ODD, types_pkg parity type; EVEN means stored word has an even number of ones, ODD an odd number
PARITY_BIT_CHOICE, MSB, types_pkg position of the parity bit in the stored word (MSB or LSB); internal layout only
ERR_CNT_WIDTH, 8, width of the saturating parity-error counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
push_valid_i  in  NUM_CH  per-channel push request
push_data_i  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
push_inject_err_i  in  NUM_CH  when set with an accepted push, the stored parity bit is inverted
push_grant_o  out  NUM_CH  channel has free space
valid_o  out  1  pop word available
data_o  out  DATA_WIDTH  pop payload (parity stripped)
channel_o  out  $clog2(NUM_CH)  source channel of data_o
parity_err_o  out  1  stored parity of the current pop word mismatches its data
grant_i  in  1  consumer accepts the pop word
err_count_o  out  ERR_CNT_WIDTH  number of popped words with parity error, saturating
err_count_clr_i  in  1  synchronous clear of err_count_o

Behaviour:
- Reset (asynchronous, any time including mid-transfer): all queues emptied, pointers 0, valid_o=0, data_o=0, channel_o=0, parity_err_o=0, err_count_o=0, round-robin pointer = NUM_CH-1 so channel 0 is served first.
- push_grant_o[c] = (count[c] != DEPTH). It depends only on occupancy, never on push_valid_i or pop activity in the same cycle.
- Push on channel c is accepted at a rising edge when push_valid_i[c] and push_grant_o[c] are both 1. All channels may push in the same cycle.
- Push parity: p = ^data for EVEN, ~^data for ODD, XOR push_inject_err_i[c]. The stored word is {p,data} for MSB or {data,p} for LSB.
- Write and read pointers wrap from DEPTH-1 to 0. count[c] is held in $clog2(DEPTH+1) bits.
- Output register: a single slot drives valid_o, data_o, channel_o and parity_err_o.
- The slot is loadable when valid_o==0, or when valid_o==1 and grant_i==1 (a transfer) at the same edge.
- When loadable and any queue is non-empty, the arbiter selects the first non-empty channel after the round-robin pointer, scanning cyclically. It pops that queue head into the slot, sets valid_o=1, and sets the round-robin pointer to the selected channel.
- When loadable and all queues are empty, valid_o goes to 0 (after a transfer) or stays 0.
- While valid_o==1 and grant_i==0, all output fields hold stable. Queues are not popped.
- Latency: a word pushed into an empty design at edge N appears with valid_o=1 after edge N+1. Back-to-back transfers sustain 1 word/cycle.
- The same queue may be pushed and popped at one edge: count is unchanged. A full queue popped at edge N shows push_grant_o=1 after edge N. A push to it at edge N is still refused.
- parity_err_o is computed at load time: parity of the loaded word, including its stored bit, checked against PARITY_MODE.
- err_count_o increments by 1 on each transfer with parity_err_o=1 and saturates at all-ones.
- err_count_clr_i has priority over increment: the counter becomes 0.
- Data order within a channel is strict FIFO. No ordering is guaranteed across channels beyond round-robin fairness.

Test Plan:
1. Reset, then push 0x155 on ch0 at cycle 1 with grant_i=1 throughout -> valid_o=1, data_o=0x155, channel_o=0, parity_err_o=0 after edge 2. valid_o=0 at cycle 3.
2. Preload ch1=0x001, ch2=0x002, ch3=0x003 (two words each), then hold grant_i=1 -> pop channel order 1,2,3,1,2,3 on consecutive cycles, followed by valid_o=0.
3. With grant_i=0, push 12 words on ch0 -> push_grant_o[0]=0 after the 12th accept. The 13th push is refused. valid_o stays 1 with data stable. Raise grant_i for one cycle -> push_grant_o[0]=1 on the next cycle.
4. Push 0x3FF with push_inject_err_i=1, then 0x000 normally; pop both -> parity_err_o=1 then 0, err_count_o=1. Pulse err_count_clr_i -> err_count_o=0.
5. Inject 300 errors -> err_count_o saturates at 255.
6. Assert reset mid-burst with 5 words queued and valid_o=1 -> all outputs 0 immediately. After release, a new push appears with 2-cycle latency and no stale data is popped.
